rv_alu_pipe: RTL and testbench

Parametrised successor to the team's 3-stage RV32I ALU pipeline. It accepts R-type (OP) and I-type (OP-IMM) integer instructions over a valid/ready handshake and decodes them. It reads operands from an internal 32-entry register file with an EX-to-decode forwarding path, executes, and writes back. Results stream out with backpressure, and unsupported encodings are flagged. It sits between the instruction source and the commit/trace logic of the integer core.

---
 rtl/rv_alu_pkg.sv | 33 +++
 rtl/rv_alu_pipe_alu.sv | 41 ++++
 rtl/rv_alu_pipe.sv | 187 ++++++++++++++++++
 tb/tb_rv_alu_pipe.sv | 576 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared opcodes, funct fields and ALU operation encoding
// for the RV32I/RV64I integer ALU pipeline.
package rv_alu_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rv_alu_pipe_alu.sv
// Combinational integer ALU.
// Ports: operand_a, operand_b, alu_op in; result out.
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;

  assign shamt = operand_b[SHW-1:0];
  assign lt_s  = $signed(operand_a) < $signed(operand_b);
  assign lt_u  = operand_a < operand_b;

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD:  result = operand_a + operand_b;
      ALU_SUB:  result = operand_a - operand_b;
      ALU_AND:  result = operand_a & operand_b;
      ALU_OR:   result = operand_a | operand_b;
      ALU_XOR:  result = operand_a ^ operand_b;
      ALU_SLL:  result = operand_a << shamt;
      ALU_SRL:  result = operand_a >> shamt;
      ALU_SRA:  result = $signed(operand_a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu_pipe.sv
// 3-stage OP/OP-IMM ALU pipeline with register file.
// Ports: clk/reset, instr handshake, res handshake, dbg read.
module rv_alu_pipe
  import rv_alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int SHW    = $clog2(XLEN),
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_data,
  output logic            res_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // upper shift funct field value that selects SRAI
  localparam logic [11:0] SH_ALT = 12'h400 >> SHW;

  logic            stall, hazard_stall;
  logic            s1_valid;
  logic [31:0]     s1_instr;
  logic            s2_valid, s2_illegal;
  alu_op_e         s2_op;
  logic [4:0]      s2_rd;
  logic [XLEN-1:0] s2_a, s2_b;
  logic            s3_valid, s3_illegal;
  logic [4:0]      s3_rd;
  logic [XLEN-1:0] s3_data;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd;
  logic [11:0]     hi;
  logic [XLEN-1:0] imm;
  alu_op_e         dec_op;
  logic            dec_illegal;
  logic            use_imm, use_rs1, use_rs2;
  logic            raw1, raw2, fwd1, fwd2, s2_wr;
  logic [XLEN-1:0] op_a, op_b, alu_res;

  assign opc = s1_instr[6:0];
  assign rd  = s1_instr[11:7];
  assign f3  = s1_instr[14:12];
  assign rs1 = s1_instr[19:15];
  assign rs2 = s1_instr[24:20];
  assign f7  = s1_instr[31:25];
  assign hi  = s1_instr[31:20] >> SHW;
  assign imm = {{(XLEN-12){s1_instr[31]}},
                s1_instr[31:20]};

  always_comb begin
    dec_op      = ALU_ADD;
    dec_illegal = 1'b1;
    use_imm     = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    unique case (1'b1)
      (opc == OPCODE_OP): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f7 == F7_BASE) begin
          dec_illegal = 1'b0;
          unique case (f3)
            F3_ADD:  dec_op = ALU_ADD;
            F3_SLL:  dec_op = ALU_SLL;
            F3_SLT:  dec_op = ALU_SLT;
            F3_SLTU: dec_op = ALU_SLTU;
            F3_XOR:  dec_op = ALU_XOR;
            F3_SRL:  dec_op = ALU_SRL;
            F3_OR:   dec_op = ALU_OR;
            F3_AND:  dec_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          dec_illegal = 1'b0;
          dec_op      = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SRL) begin
          dec_illegal = 1'b0;
          dec_op      = ALU_SRA;
        end
      end
      (opc == OPCODE_OP_IMM): begin
        use_rs1     = 1'b1;
        use_imm     = 1'b1;
        dec_illegal = 1'b0;
        unique case (f3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_OR:   dec_op = ALU_OR;
          F3_AND:  dec_op = ALU_AND;
          F3_SLL: begin
            dec_op      = ALU_SLL;
            dec_illegal = (hi != '0);
          end
          F3_SRL: begin
            dec_op      = (hi == SH_ALT) ? ALU_SRA
                                         : ALU_SRL;
            dec_illegal = (hi != '0) &&
                          (hi != SH_ALT);
          end
        endcase
      end
      default: ;
    endcase
  end

  assign s2_wr = s2_valid & ~s2_illegal & (|s2_rd);
  assign raw1  = s2_wr & use_rs1 & (s2_rd == rs1);
  assign raw2  = s2_wr & use_rs2 & (s2_rd == rs2);
  assign fwd1  = FWD_EN && raw1;
  assign fwd2  = FWD_EN && raw2;

  assign hazard_stall = !FWD_EN && s1_valid &&
                        (raw1 || raw2);

  assign op_a = (rs1 == 5'd0) ? '0 :
                fwd1 ? alu_res : rf[rs1];
  assign op_b = use_imm ? imm :
                (rs2 == 5'd0) ? '0 :
                fwd2 ? alu_res : rf[rs2];

  assign stall       = s3_valid & ~res_ready;
  assign instr_ready = ~stall & ~hazard_stall;

  rv_alu #(.XLEN(XLEN)) u_alu (
    .operand_a (s2_a),
    .operand_b (s2_b),
    .alu_op    (s2_op),
    .result    (alu_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s2_valid   <= 1'b0;
      s2_illegal <= 1'b0;
      s2_op      <= ALU_ADD;
      s2_rd      <= '0;
      s2_a       <= '0;
      s2_b       <= '0;
      s3_valid   <= 1'b0;
      s3_illegal <= 1'b0;
      s3_rd      <= '0;
      s3_data    <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!stall) begin
      s3_valid   <= s2_valid;
      s3_rd      <= s2_rd;
      s3_illegal <= s2_valid & s2_illegal;
      s3_data    <= (s2_valid & ~s2_illegal)
                    ? alu_res : '0;
      if (s2_wr) rf[s2_rd] <= alu_res;
      if (hazard_stall) begin
        // S1 holds; a bubble enters S2
        s2_valid <= 1'b0;
      end else begin
        s2_valid   <= s1_valid;
        s2_illegal <= dec_illegal;
        s2_op      <= dec_op;
        s2_rd      <= rd;
        s2_a       <= op_a;
        s2_b       <= op_b;
        s1_valid   <= instr_valid;
        s1_instr   <= instr;
      end
    end
  end

  assign res_valid   = s3_valid;
  assign res_rd      = s3_rd;
  assign res_data    = s3_data;
  assign res_illegal = s3_illegal;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0
                                          : rf[dbg_addr];

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Self-checking bench for rv_alu_pipe: main XLEN=32 forwarding
// instance plus a no-forwarding and an XLEN=64 instance.
module tb_rv_alu_pipe;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
    logic        wr;
  } exp_t;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [4:0]  res_rd;
  logic [31:0] res_data;
  logic        res_illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic        n_ivalid = 1'b0;
  logic        n_iready;
  logic [31:0] n_instr = '0;
  logic        n_rvalid;
  logic        n_rready = 1'b1;
  logic [4:0]  n_rd;
  logic [31:0] n_data;
  logic        n_ill;
  logic [4:0]  n_dbg_addr = '0;
  logic [31:0] n_dbg_data;

  logic        w_ivalid = 1'b0;
  logic        w_iready;
  logic [31:0] w_instr = '0;
  logic        w_rvalid;
  logic        w_rready = 1'b1;
  logic [4:0]  w_rd;
  logic [63:0] w_data;
  logic        w_ill;
  logic [4:0]  w_dbg_addr = '0;
  logic [63:0] w_dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] gold [32];
  exp_t        q [$];

  always #5 clk = ~clk;

  rv_alu_pipe #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_rd(res_rd), .res_data(res_data),
    .res_illegal(res_illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  rv_alu_pipe #(.XLEN(32), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset),
    .instr_valid(n_ivalid), .instr_ready(n_iready),
    .instr(n_instr),
    .res_valid(n_rvalid), .res_ready(n_rready),
    .res_rd(n_rd), .res_data(n_data),
    .res_illegal(n_ill),
    .dbg_addr(n_dbg_addr), .dbg_data(n_dbg_data)
  );

  rv_alu_pipe #(.XLEN(64), .FWD_EN(1'b1)) dut_w (
    .clk(clk), .reset(reset),
    .instr_valid(w_ivalid), .instr_ready(w_iready),
    .instr(w_instr),
    .res_valid(w_rvalid), .res_ready(w_rready),
    .res_rd(w_rd), .res_data(w_data),
    .res_illegal(w_ill),
    .dbg_addr(w_dbg_addr), .dbg_data(w_dbg_data)
  );

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // ISA-level reference: executes one instruction in program order
  function automatic exp_t ref_exec(input logic [31:0] i);
    exp_t        e;
    logic [31:0] a, b, im, r;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        ok;
    f7 = i[31:25];
    f3 = i[14:12];
    a  = gold[i[19:15]];
    b  = gold[i[24:20]];
    im = {{20{i[31]}}, i[31:20]};
    r  = '0;
    ok = 1'b0;
    if (i[6:0] == 7'b0110011) begin
      ok = 1'b1;
      case ({f7, f3})
        {7'h00, 3'd0}: r = a + b;
        {7'h20, 3'd0}: r = a - b;
        {7'h00, 3'd1}: r = a << b[4:0];
        {7'h00, 3'd2}: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: r = (a < b) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: r = a ^ b;
        {7'h00, 3'd5}: r = a >> b[4:0];
        {7'h20, 3'd5}: r = $signed(a) >>> b[4:0];
        {7'h00, 3'd6}: r = a | b;
        {7'h00, 3'd7}: r = a & b;
        default:       ok = 1'b0;
      endcase
    end else if (i[6:0] == 7'b0010011) begin
      ok = 1'b1;
      case (f3)
        3'd0: r = a + im;
        3'd2: r = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
        3'd3: r = (a < im) ? 32'd1 : 32'd0;
        3'd4: r = a ^ im;
        3'd6: r = a | im;
        3'd7: r = a & im;
        3'd1: if (f7 == 7'h00) r = a << i[24:20];
              else ok = 1'b0;
        default: begin
          if (f7 == 7'h00) r = a >> i[24:20];
          else if (f7 == 7'h20) r = $signed(a) >>> i[24:20];
          else ok = 1'b0;
        end
      endcase
    end
    e.rd   = i[11:7];
    e.ill  = !ok;
    e.data = ok ? r : 32'd0;
    e.wr   = ok && (i[11:7] != 5'd0);
    return e;
  endfunction

  task automatic model_apply(input logic [31:0] i, output exp_t e);
    e = ref_exec(i);
    if (e.wr) gold[e.rd] = e.data;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    int          k;
    rd  = 5'($urandom_range(7));
    rs1 = 5'($urandom_range(7));
    rs2 = 5'($urandom_range(7));
    f3  = 3'($urandom_range(7));
    imm = 12'($urandom);
    k   = $urandom_range(9);
    if (k < 4) begin
      if ($urandom_range(3) == 0) f7 = 7'($urandom);
      else f7 = $urandom_range(1) ? 7'h20 : 7'h00;
      return enc_r(f7, f3, rd, rs1, rs2);
    end else if (k < 8) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        case ($urandom_range(3))
          0: imm[11:5] = 7'h00;
          1: imm[11:5] = 7'h20;
          2: imm[11:5] = 7'h00;
          default: ;
        endcase
      end
      return enc_i(f3, rd, rs1, imm);
    end else if (k == 8) begin
      return 32'($urandom);
    end
    return 32'h0000007F;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] i,
                       input logic rr, output obs_t o);
    @(negedge clk);
    instr_valid = v;
    instr       = i;
    res_ready   = rr;
    #1;
    o.valid = res_valid;
    o.ready = instr_ready;
    o.rd    = res_rd;
    o.data  = res_data;
    o.ill   = res_illegal;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({res_valid, res_rd, res_data, res_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rd=%0d d=%h il=%b, required all 0",
               res_valid, res_rd, res_data, res_illegal);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", instr_ready);
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_rf x%0d: got %h, required 0", r, dbg_data);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] prog [10];
    logic [4:0]  xrd  [10];
    logic [31:0] xdat [10];
    logic        xill [10];
    obs_t        o;
    exp_t        e;
    int          pi, got;
    prog[0] = enc_i(3'd0, 5'd1, 5'd0, 12'hFFB);
    prog[1] = enc_i(3'd0, 5'd2, 5'd0, 12'h003);
    prog[2] = enc_r(7'h20, 3'd0, 5'd3, 5'd1, 5'd2);
    prog[3] = enc_r(7'h00, 3'd2, 5'd4, 5'd1, 5'd2);
    prog[4] = enc_r(7'h00, 3'd3, 5'd4, 5'd1, 5'd2);
    prog[5] = enc_i(3'd0, 5'd1, 5'd3, 12'h000);
    prog[6] = enc_i(3'd5, 5'd7, 5'd1, 12'h401);
    prog[7] = enc_i(3'd5, 5'd9, 5'd1, 12'h001);
    prog[8] = enc_i(3'd0, 5'd0, 5'd0, 12'h009);
    prog[9] = 32'h0000007F;
    xrd  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd1, 5'd7, 5'd9, 5'd0, 5'd0};
    xdat = '{32'hFFFFFFFB, 32'd3, 32'hFFFFFFF8, 32'd1, 32'd0,
             32'hFFFFFFF8, 32'hFFFFFFFC, 32'h7FFFFFFC, 32'd9, 32'd0};
    xill = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    pi  = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      cycle(pi < 10, (pi < 10) ? prog[pi] : 32'd0, 1'b1, o);
      if (o.valid) begin
        checks++;
        if ({o.rd, o.data, o.ill} !== {xrd[got], xdat[got], xill[got]}) begin
          errors++;
          $display("FAIL directed[%0d]: got rd=%0d d=%h il=%b, required rd=%0d d=%h il=%b",
                   got, o.rd, o.data, o.ill, xrd[got], xdat[got], xill[got]);
        end
        got++;
      end
      if (pi < 10 && o.ready) begin
        model_apply(prog[pi], e);
        pi++;
      end
    end
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL directed_timeout: got %0d results, required 10", got);
    end
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL x0_read: got %h, required 0", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [2];
    obs_t        o;
    exp_t        e;
    int          pi, got, zeros, acc_c;
    int          out_c [2];
    prog[0] = enc_i(3'd0, 5'd5, 5'd0, 12'd7);
    prog[1] = enc_r(7'h00, 3'd0, 5'd6, 5'd5, 5'd5);
    pi = 0; got = 0; zeros = 0; acc_c = -1;
    for (int c = 0; c < 30 && got < 2; c++) begin
      cycle(pi < 2, (pi < 2) ? prog[pi] : 32'd0, 1'b1, o);
      if (!o.ready) zeros++;
      if (o.valid && got < 2) begin
        checks++;
        if ({o.rd, o.data} !== {(got == 0) ? 5'd5 : 5'd6,
                                (got == 0) ? 32'd7 : 32'd14}) begin
          errors++;
          $display("FAIL b2b_fwd[%0d]: got rd=%0d d=%h", got, o.rd, o.data);
        end
        out_c[got] = c;
        got++;
      end
      if (pi < 2 && o.ready) begin
        if (pi == 0) acc_c = c;
        model_apply(prog[pi], e);
        pi++;
      end
    end
    checks++;
    if (got != 2 || zeros != 0 || out_c[0] != acc_c + 3 ||
        out_c[1] != out_c[0] + 1) begin
      errors++;
      $display("FAIL b2b_fwd_timing: got=%0d zeros=%0d acc=%0d out=%0d/%0d, required 2 0 lat3 back-to-back",
               got, zeros, acc_c, out_c[0], out_c[1]);
    end
    pi = 0; got = 0; zeros = 0;
    for (int c = 0; c < 30 && got < 2; c++) begin
      @(negedge clk);
      n_ivalid = (pi < 2);
      n_instr  = (pi < 2) ? prog[pi] : 32'd0;
      n_rready = 1'b1;
      #1;
      if (!n_iready) zeros++;
      if (n_rvalid && got < 2) begin
        checks++;
        if ({n_rd, n_data} !== {(got == 0) ? 5'd5 : 5'd6,
                                (got == 0) ? 32'd7 : 32'd14}) begin
          errors++;
          $display("FAIL b2b_nofwd[%0d]: got rd=%0d d=%h", got, n_rd, n_data);
        end
        got++;
      end
      if (n_ivalid && n_iready) pi++;
    end
    n_ivalid = 1'b0;
    checks++;
    if (got != 2 || zeros != 1) begin
      errors++;
      $display("FAIL b2b_nofwd_stall: got=%0d ready_low=%0d, required 2 and 1", got, zeros);
    end
    n_dbg_addr = 5'd6;
    #1;
    checks++;
    if (n_dbg_data !== 32'd14) begin
      errors++;
      $display("FAIL nofwd_x6: got %h, required 0000000e", n_dbg_data);
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] prog [5];
    logic [4:0]  xrd  [5];
    logic [63:0] xdat [5];
    int          pi, got;
    prog[0] = enc_i(3'd0, 5'd2, 5'd0, 12'd3);
    prog[1] = enc_i(3'd1, 5'd8, 5'd2, 12'd40);
    prog[2] = enc_i(3'd0, 5'd10, 5'd0, 12'hFF8);
    prog[3] = enc_i(3'd5, 5'd11, 5'd10, 12'h424);
    prog[4] = enc_i(3'd1, 5'd12, 5'd2, 12'h020);
    xrd  = '{5'd2, 5'd8, 5'd10, 5'd11, 5'd12};
    xdat = '{64'd3, 64'd3 << 40, 64'hFFFFFFFFFFFFFFF8,
             64'hFFFFFFFFFFFFFFFF, 64'd3 << 32};
    pi = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      w_ivalid = (pi < 5);
      w_instr  = (pi < 5) ? prog[pi] : 32'd0;
      w_rready = 1'b1;
      #1;
      if (w_rvalid && got < 5) begin
        checks++;
        if ({w_rd, w_data, w_ill} !== {xrd[got], xdat[got], 1'b0}) begin
          errors++;
          $display("FAIL x64[%0d]: got rd=%0d d=%h il=%b, required rd=%0d d=%h il=0",
                   got, w_rd, w_data, w_ill, xrd[got], xdat[got]);
        end
        got++;
      end
      if (w_ivalid && w_iready) pi++;
    end
    w_ivalid = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL x64_timeout: got %0d results, required 5", got);
    end
    w_dbg_addr = 5'd8;
    #1;
    checks++;
    if (w_dbg_data !== (64'd3 << 40)) begin
      errors++;
      $display("FAIL x64_x8: got %h, required %h", w_dbg_data, 64'd3 << 40);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prog [3];
    obs_t        o, snap;
    exp_t        e;
    int          got;
    prog[0] = enc_i(3'd0, 5'd10, 5'd0, 12'd100);
    prog[1] = enc_i(3'd0, 5'd11, 5'd10, 12'hFFF);
    prog[2] = enc_r(7'h00, 3'd4, 5'd12, 5'd11, 5'd10);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, prog[i], 1'b0, o);
      checks++;
      if (!o.ready) begin
        errors++;
        $display("FAIL bp_accept[%0d]: got ready 0, required 1", i);
      end else begin
        model_apply(prog[i], e);
        q.push_back(e);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, snap);
    checks++;
    if (!snap.valid || snap.ready) begin
      errors++;
      $display("FAIL bp_full: got valid=%b ready=%b, required 1 0", snap.valid, snap.ready);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h0000007F, 1'b0, o);
      checks++;
      if (o !== snap) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h, required %h", i, o, snap);
      end
    end
    got = 0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      cycle(1'b0, 32'd0, 1'b1, o);
      if (o.valid) begin
        e = q.pop_front();
        checks++;
        if ({o.rd, o.data, o.ill} !== {e.rd, e.data, e.ill}) begin
          errors++;
          $display("FAIL bp_result[%0d]: got rd=%0d d=%h il=%b, required rd=%0d d=%h il=%b",
                   got, o.rd, o.data, o.ill, e.rd, e.data, e.ill);
        end
        got++;
      end
    end
    cycle(1'b0, 32'd0, 1'b1, o);
    checks++;
    if (got != 3 || o.valid) begin
      errors++;
      $display("FAIL bp_count: got %0d results valid_after=%b, required 3 and 0", got, o.valid);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        v, rr;
    logic [31:0] ins;
    for (int c = 0; c < 500; c++) begin
      v   = ($urandom_range(3) != 0);
      rr  = ($urandom_range(3) != 0);
      ins = gen_instr();
      cycle(v, ins, rr, o);
      checks++;
      if (o.ready !== !(o.valid && !rr)) begin
        errors++;
        $display("FAIL rand_ready: got %b, valid=%b res_ready=%b", o.ready, o.valid, rr);
      end
      if (o.valid && rr) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got rd=%0d d=%h, required no result", o.rd, o.data);
        end else begin
          e = q.pop_front();
          if ({o.rd, o.data, o.ill} !== {e.rd, e.data, e.ill}) begin
            errors++;
            $display("FAIL rand_result: got rd=%0d d=%h il=%b, required rd=%0d d=%h il=%b",
                     o.rd, o.data, o.ill, e.rd, e.data, e.ill);
          end
        end
      end
      if (v && o.ready) begin
        model_apply(ins, e);
        q.push_back(e);
      end
    end
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      cycle(1'b0, 32'd0, 1'b1, o);
      if (o.valid) begin
        e = q.pop_front();
        checks++;
        if ({o.rd, o.data, o.ill} !== {e.rd, e.data, e.ill}) begin
          errors++;
          $display("FAIL rand_drain: got rd=%0d d=%h il=%b, required rd=%0d d=%h il=%b",
                   o.rd, o.data, o.ill, e.rd, e.data, e.ill);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout: %0d results missing, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_regfile();
    for (int r = 0; r < 32; r++) begin
      dbg_addr = 5'(r);
      #1;
      checks++;
      if (dbg_data !== gold[r]) begin
        errors++;
        $display("FAIL rf x%0d: got %h, required %h", r, dbg_data, gold[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, enc_i(3'd0, 5'(20 + i), 5'd0, 12'(i + 1)), 1'b0, o);
    cycle(1'b0, 32'd0, 1'b0, o);
    checks++;
    if (!o.valid) begin
      errors++;
      $display("FAIL rstmid_pre: got valid 0, required 1");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({res_valid, res_rd, res_data, res_illegal} !== '0) begin
      errors++;
      $display("FAIL rstmid_out: got v=%b rd=%0d d=%h il=%b, required all 0",
               res_valid, res_rd, res_data, res_illegal);
    end
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 32; r++) gold[r] = '0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post: got valid=%b ready=%b, required 0 1", res_valid, instr_ready);
    end
    test_regfile();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) gold[r] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_xlen64();
    test_backpressure();
    test_random();
    test_regfile();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
